cla_mp_seq: RTL and testbench
=============================

// Module: cla_mp_seq
// PURPOSE
//  Multi-precision add/subtract sequencer built on one 16-bit carry-lookahead adder (cla).
//  Takes WORDS*16-bit operands and issues one 16-bit slice per cycle, LSW first.
//  Each slice's carry-out is registered and fed into the next slice.
//  Sits between a valid/ready producer and a valid/ready consumer.
// PARAMETERS
//  WORDS  4  number of 16-bit slices; operand width N = 16*WORDS; legal range 1..16
// PORTS
//  clk        in   1   single clock; all state changes on rising edge
//  rst_n      in   1   reset: synchronous, active-low
//  in_valid   in   1   producer has an operation
//  in_ready   out  1   sequencer can accept; high only in IDLE
//  in_sub     in   1   0: a+b; 1: a-b, computed as a+~b+1
//  in_a       in   N   operand A, unsigned or two's complement
//  in_b       in   N   operand B
//  out_valid  out  1   result held valid
//  out_ready  in   1   consumer accepts the result
//  out_sum    out  N   result modulo 2^N
//  out_co     out  1   carry-out of the MS slice; for sub, 1 means no borrow
//  out_ovf    out  1   signed overflow of the N-bit operation
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_co=0, out_ovf=0,
//    slice index=0, carry reg=0.
//  - States:
//    IDLE -(in_valid)-> RUN
//    RUN  -(idx==WORDS-1)-> DONE
//    DONE -(out_ready)-> IDLE
//  - Accept edge (IDLE & in_valid):
//    latch a; latch b, inverted when in_sub=1; latch in_sub; idx=0; carry reg=in_sub.
//  - RUN, per cycle:
//    cla.a = a slice[idx], cla.b = b slice[idx], cla.ci = carry reg.
//    At the edge: store s into out_sum slice[idx], carry reg = co, idx++.
//  - Last slice (idx==WORDS-1): also capture out_co=co and
//    out_ovf = (a_msb==b'_msb) & (s_msb!=a_msb), where b' is the post-inversion operand.
//  - Latency: out_valid rises exactly WORDS+1 edges after the accept edge
//    (1 load edge + WORDS slice edges).
//  - DONE: out_valid=1. out_sum/out_co/out_ovf stable until out_ready is sampled high.
//    The handshake edge returns to IDLE and drops out_valid.
//    No new accept on that same edge; in_ready rises the following cycle.
//    Back-to-back throughput: one op per WORDS+2 cycles.
//  - in_ready=0 in RUN and DONE: in_valid and operand changes there are ignored,
//    since operands are latched.
//  - out_sum slices not yet written during RUN hold stale data. Consumers use them only
//    with out_valid.
//  - Reset mid-RUN or mid-DONE: the operation is discarded and all outputs return to
//    reset values on that edge.
//  - Wrap-around: results are modulo 2^N; carry/borrow is reported only through out_co.
//  - WORDS=1: RUN lasts one cycle; identical to a single registered cla add.
// STRUCTURE
//  - Shared package: localparam SLICE_W=16.
//    State enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 decodes to IDLE.
//  - One sub-module instance: cla (16-bit CLA datapath), unmodified.
//  - Controller, slice mux, and result/carry registers live in this module.
// TESTING
//  1. Reset held 3 cycles with in_valid=1 -> in_ready=1, out_valid=0, outputs 0, no accept.
//  2. WORDS=4, add a=0x0000_0000_0000_FFFF, b=1 ->
//     sum=0x0000_0000_0001_0000, co=0, ovf=0; out_valid 5 edges after accept.
//  3. add a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> sum=0, co=1, ovf=0 (full carry ripple across 4 slices).
//  4. sub a=0x8000_0000_0000_0000, b=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, co=1, ovf=1;
//     sub a=0, b=1 -> sum=all-ones, co=0, ovf=0.
//  5. out_ready low 10 cycles in DONE -> outputs stable, in_ready=0;
//     operands changed in RUN do not alter the result.
//  6. rst_n low for 1 cycle at RUN idx=2 -> next cycle IDLE, out_valid=0.
//     A following add 3+4 -> sum=7.

Source files
------------

// File: rtl/cla_mp_seq_pkg.sv
// rtl/cla_mp_seq_pkg.sv - shared constants and state encoding for the multi-precision add/sub sequencer
package cla_mp_seq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_mp_seq_if.sv
// rtl/cla_mp_seq_if.sv - producer/consumer handshake bundle for cla_mp_seq
interface cla_mp_seq_if #(parameter int WORDS = 4);
  import cla_mp_seq_pkg::*;

  localparam int N = SLICE_W * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic         in_sub;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_co;
  logic         out_ovf;

  modport master (
    output in_valid, in_sub, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_co, out_ovf
  );

  modport slave (
    input  in_valid, in_sub, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_co, out_ovf
  );

endinterface

// File: rtl/cla_mp_seq_cla.sv
// rtl/cla_mp_seq_cla.sv - 16-bit two-level carry-lookahead adder (4-bit groups)
module cla_mp_seq_cla (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;
  logic [15:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    gp = '0;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  // Group carries resolved in closed form so no carry waits on another group's ripple
  always_comb begin
    gc    = '0;
    gc[0] = ci;
    gc[1] = gg[0] | (gp[0] & ci);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & ci);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & ci);
  end

  always_comb begin
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign s  = p ^ c;
  assign co = gc[4];

endmodule

// File: rtl/cla_mp_seq.sv
// rtl/cla_mp_seq.sv - multi-precision add/sub sequencer, one 16-bit CLA slice per cycle, LSW first
module cla_mp_seq
  import cla_mp_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  cla_mp_seq_if.slave    bus
);

  localparam int N     = SLICE_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t             state;
  state_t             state_nxt;
  logic [N-1:0]       a_q;
  logic [N-1:0]       b_q;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic               last;
  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_s;
  logic               sl_co;

  assign last = (idx == IDX_W'(WORDS - 1));
  assign sl_a = a_q[idx*SLICE_W +: SLICE_W];
  assign sl_b = b_q[idx*SLICE_W +: SLICE_W];

  cla_mp_seq_cla u_cla (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry),
    .s  (sl_s),
    .co (sl_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Unused encoding 2'd3 falls into the default arm and behaves as IDLE
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      ST_RUN: begin
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = ST_IDLE;
      end
      default: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      idx         <= '0;
      carry       <= 1'b0;
      bus.out_sum <= '0;
      bus.out_co  <= 1'b0;
      bus.out_ovf <= 1'b0;
    end else if (bus.in_ready && bus.in_valid) begin
      // Subtraction becomes a + ~b + 1 with the +1 entering as the first slice carry
      a_q   <= bus.in_a;
      b_q   <= bus.in_sub ? ~bus.in_b : bus.in_b;
      idx   <= '0;
      carry <= bus.in_sub;
    end else if (state == ST_RUN) begin
      bus.out_sum[idx*SLICE_W +: SLICE_W] <= sl_s;
      carry <= sl_co;
      if (last) begin
        idx         <= '0;
        bus.out_co  <= sl_co;
        bus.out_ovf <= (a_q[N-1] == b_q[N-1]) && (sl_s[SLICE_W-1] != a_q[N-1]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cla_mp_seq.sv
// tb/tb_cla_mp_seq.sv - directed self-checking bench for cla_mp_seq (WORDS=4)
module tb_cla_mp_seq;

  localparam int WORDS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  cla_mp_seq_if #(.WORDS(WORDS)) bus ();

  cla_mp_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issues one op, waits for out_valid (bounded), checks results and latency, then handshakes.
  // hold = cycles out_ready stays low in DONE; scramble = wiggle inputs while busy.
  task automatic run_op(input string tag, input logic sub, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_sum,
                        input logic exp_co, input logic exp_ovf,
                        input int hold, input bit scramble);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_sub   = sub;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = scramble;
    while (!bus.out_valid && lat < 50) begin
      if (scramble) begin
        bus.in_a   = {$urandom, $urandom};
        bus.in_b   = {$urandom, $urandom};
        bus.in_sub = ~sub;
        chk({tag, "_busy_in_ready"}, 64'(bus.in_ready), 64'd0);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 64'(lat), 64'(WORDS + 1));
    chk({tag, "_sum"}, bus.out_sum, exp_sum);
    chk({tag, "_co"},  64'(bus.out_co), 64'(exp_co));
    chk({tag, "_ovf"}, 64'(bus.out_ovf), 64'(exp_ovf));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, "_hold_ready"}, 64'(bus.in_ready), 64'd0);
      chk({tag, "_hold_sum"}, bus.out_sum, exp_sum);
      chk({tag, "_hold_flags"}, {62'd0, bus.out_co, bus.out_ovf}, {62'd0, exp_co, exp_ovf});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_post_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_post_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b1;
    bus.in_sub    = 1'b0;
    bus.in_a      = 64'h1234_5678_9ABC_DEF0;
    bus.in_b      = 64'h1111_1111_1111_1111;
    bus.out_ready = 1'b0;

    // Reset held 3 cycles with in_valid high: nothing accepted
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_sum",   bus.out_sum, 64'd0);
    chk("rst_flags",     {62'd0, bus.out_co, bus.out_ovf}, 64'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_no_accept", 64'(bus.in_ready), 64'd1);

    run_op("add_lsw_carry", 1'b0, 64'h0000_0000_0000_FFFF, 64'd1,
           64'h0000_0000_0001_0000, 1'b0, 1'b0, 0, 1'b0);
    run_op("add_full_ripple", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
           64'd0, 1'b1, 1'b0, 0, 1'b0);
    run_op("sub_min_ovf", 1'b1, 64'h8000_0000_0000_0000, 64'd1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0, 1'b0);
    run_op("sub_borrow", 1'b1, 64'd0, 64'd1,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 1'b0);
    run_op("add_pos_ovf", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
           64'h8000_0000_0000_0000, 1'b0, 1'b1, 0, 1'b0);
    run_op("hold_scramble", 1'b0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111,
           64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 10, 1'b1);

    // Reset pulse while the slice index is 2
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sub   = 1'b0;
    bus.in_a     = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.in_b     = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_run_busy", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_in_ready",  64'(bus.in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_out_sum",   bus.out_sum, 64'd0);
    chk("mid_rst_flags",     {62'd0, bus.out_co, bus.out_ovf}, 64'd0);

    run_op("add_after_rst", 1'b0, 64'd3, 64'd4, 64'd7, 1'b0, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
